// File: rtl/uart_rom_loader.sv
// UART program downloader: receives 8N1 bytes, packs them little-endian into
// 32-bit words and writes them to the instruction ROM while holding the core.
module uart_rom_loader #(
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en_i,
  input  logic        uart_rx_i,
  output logic        wen_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        hold_o,
  output logic        err_o,
  output logic [15:0] word_cnt_o
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          rx_m, rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_clr, shift, byte_vld, frm_err;

  logic          load_q, start, fall;
  logic [1:0]    idx;
  logic [31:0]   pack, pack_nxt;
  logic          emit, drop_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // byte_vld/frm_err come from the STOP sample even in the cycle load_en_i
  // falls, so a frame finishing on that edge is still packed and flushed.
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift    = 1'b0;
    byte_vld = 1'b0;
    frm_err  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_n = START;
      end
      START: if (baud_cnt == HALF_M1) begin
        cnt_clr = 1'b1;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (baud_cnt == FULL_M1) begin
        cnt_clr = 1'b1;
        shift   = 1'b1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (baud_cnt == FULL_M1) begin
        cnt_clr = 1'b1;
        state_n = IDLE;
        if (rx_s) byte_vld = 1'b1;
        else      frm_err  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (!load_en_i) begin
      state_n = IDLE;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
      if (state != DATA) bit_idx <= '0;
      else if (shift)    bit_idx <= bit_idx + 3'd1;
      if (shift) shreg <= {rx_s, shreg[7:1]};
    end
  end

  assign start = load_en_i & ~load_q;
  assign fall  = ~load_en_i & load_q;

  always_comb begin
    pack_nxt = pack;
    if (byte_vld) pack_nxt[{idx, 3'b000} +: 8] = shreg;
  end

  // A write goes out on the 4th byte, or as a flush of a partial word at session end.
  assign emit = (byte_vld && idx == 2'd3) || (fall && (idx != 2'd0 || byte_vld));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q     <= 1'b0;
      wen_o      <= 1'b0;
      w_addr_o   <= ADDR_BASE;
      w_data_o   <= '0;
      hold_o     <= 1'b0;
      err_o      <= 1'b0;
      word_cnt_o <= '0;
      idx        <= '0;
      pack       <= '0;
      drop_pend  <= 1'b0;
    end else begin
      load_q <= load_en_i;
      wen_o  <= emit;
      if (emit) w_data_o <= pack_nxt;
      if (start) begin
        w_addr_o   <= ADDR_BASE;
        word_cnt_o <= '0;
        err_o      <= 1'b0;
        idx        <= '0;
        pack       <= '0;
        hold_o     <= 1'b1;
        drop_pend  <= 1'b0;
      end else begin
        if (wen_o) begin
          w_addr_o   <= w_addr_o + 32'd4;
          word_cnt_o <= word_cnt_o + 16'd1;
        end
        if (frm_err) err_o <= 1'b1;
        if (emit) begin
          pack <= '0;
          idx  <= '0;
        end else if (byte_vld) begin
          pack <= pack_nxt;
          idx  <= idx + 2'd1;
        end
        // With a flush pending, hold stays up through the write cycle.
        if (fall) begin
          if (emit) drop_pend <= 1'b1;
          else      hold_o    <= 1'b0;
        end
        if (drop_pend) begin
          hold_o    <= 1'b0;
          drop_pend <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader at BAUD_DIV=10; a second instance covers address wrap.
module tb_uart_rom_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0, load_en2 = 1'b0;
  logic        rx = 1'b1;
  logic        wen1, hold1, err1, wen2, hold2, err2;
  logic [31:0] addr1, data1, addr2, data2;
  logic [15:0] cnt1, cnt2;
  int          n_cmp = 0, n_err = 0;
  logic [63:0] q1[$], q2[$];

  always #5 clk = ~clk;

  uart_rom_loader #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst), .load_en_i(load_en), .uart_rx_i(rx),
    .wen_o(wen1), .w_addr_o(addr1), .w_data_o(data1),
    .hold_o(hold1), .err_o(err1), .word_cnt_o(cnt1));

  uart_rom_loader #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_BASE(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .load_en_i(load_en2), .uart_rx_i(rx),
    .wen_o(wen2), .w_addr_o(addr2), .w_data_o(data2),
    .hold_o(hold2), .err_o(err2), .word_cnt_o(cnt2));

  // Every cycle with wen high is logged, so a stretched pulse shows up as an extra write.
  always @(negedge clk) begin
    if (wen1) q1.push_back({addr1, data1});
    if (wen2) q2.push_back({addr2, data2});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input int which, input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] v;
    if ((which == 1 ? q1.size() : q2.size()) == 0) begin
      chk({tag, " missing"}, 64'd0, 64'd1);
    end else begin
      v = (which == 1) ? q1.pop_front() : q2.pop_front();
      chk(tag, v, {a, d});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] seq8 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    repeat (3) @(negedge clk);
    chk("rst wen", wen1, 0);
    chk("rst addr", addr1, 32'h0);
    chk("rst data", data1, 32'h0);
    chk("rst hold", hold1, 0);
    chk("rst err", err1, 0);
    chk("rst cnt", cnt1, 0);
    chk("rst addr wrap", addr2, 32'hFFFF_FFFC);
    rst = 1'b0;

    // reset in the middle of a frame, load_en held high throughout
    load_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("session hold", hold1, 1);
    rx = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst hold", hold1, 0);
    chk("midrst cnt", cnt1, 0);
    chk("midrst wen", wen1, 0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post rst hold", hold1, 1);
    send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
    expect_wr(1, "word 12345678", 32'h0, 32'h1234_5678);
    chk("after word addr", addr1, 32'h4);
    chk("after word cnt", cnt1, 1);
    chk("single write", q1.size(), 0);

    // end session on a word boundary: no flush
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("end hold", hold1, 0);
    chk("end no flush", q1.size(), 0);
    chk("end cnt kept", cnt1, 1);

    // 8 bytes into both instances
    load_en = 1'b1; load_en2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("restart cnt", cnt1, 0);
    chk("restart addr", addr1, 32'h0);
    for (int i = 0; i < 8; i++) send_byte(seq8[i], 1);
    expect_wr(1, "w0 04030201", 32'h0, 32'h0403_0201);
    expect_wr(1, "w1 08070605", 32'h4, 32'h0807_0605);
    chk("8b cnt", cnt1, 2);
    expect_wr(2, "wrap w0", 32'hFFFF_FFFC, 32'h0403_0201);
    expect_wr(2, "wrap w1", 32'h0, 32'h0807_0605);
    chk("wrap addr", addr2, 32'h4);
    load_en = 1'b0; load_en2 = 1'b0;
    repeat (3) @(negedge clk);

    // partial word flushed on session end
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hAA, 1); send_byte(8'hBB, 1);
    chk("partial no write", q1.size(), 0);
    load_en = 1'b0;
    @(negedge clk);
    chk("flush wen", wen1, 1);
    chk("flush data", data1, 32'h0000_BBAA);
    chk("flush addr", addr1, 32'h0);
    chk("flush hold", hold1, 1);
    @(negedge clk);
    chk("flush wen off", wen1, 0);
    chk("flush hold off", hold1, 0);
    chk("flush cnt", cnt1, 1);
    chk("flush addr inc", addr1, 32'h4);
    expect_wr(1, "flush word", 32'h0, 32'h0000_BBAA);

    // framing error
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("err start", err1, 0);
    send_byte(8'h55, 0);
    repeat (20) @(negedge clk);
    chk("err set", err1, 1);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("err no byte", q1.size(), 0);
    chk("err sticky", err1, 1);
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("err cleared", err1, 0);

    // short glitch on idle line
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch err", err1, 0);
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch no byte", q1.size(), 0);
    chk("glitch hold", hold1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
